// File: rtl/inst_mem.sv
// Instruction memory with a load port and a one-entry registered fetch output stage.
// Defining INST_MEM_PARITY_EN stores an even-parity bit per word and reports mismatches on par_err.
module inst_mem #(
    parameter int DW    = 32,
    parameter int AW    = 5,
    parameter int DEPTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req,
    input  logic [AW-1:0] addr,
    output logic          req_ready,
    output logic          inst_valid,
    input  logic          inst_ready,
    output logic [DW-1:0] inst,
    input  logic          ld_en,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_data,
    output logic          par_err
);

    // Handshake: a fetch is taken on a rising edge where req && req_ready; a word
    // leaves the output stage on a rising edge where inst_valid && inst_ready.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

    state_t        state;
    state_t        state_next;
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] inst_q;
    logic          par_q;
    logic          accept;
    logic          addr_ok;
    logic          ld_ok;
    logic [DW-1:0] rd_word;
    logic          rd_par_err;

    assign addr_ok    = ({1'b0, addr} < DEPTH_W);
    assign ld_ok      = ({1'b0, ld_addr} < DEPTH_W);
    assign inst_valid = (state == FULL);
    assign req_ready  = !ld_en && (!inst_valid || inst_ready);
    assign accept     = req && req_ready;
    assign rd_word    = addr_ok ? mem[addr] : '0;
    assign inst       = inst_q;
    assign par_err    = par_q;

    always_comb begin
        state_next = state;
        case (state)
            EMPTY: if (accept) state_next = FULL;
            FULL: begin
                if (accept)          state_next = FULL;
                else if (inst_ready) state_next = EMPTY;
            end
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= EMPTY;
        else     state <= state_next;
    end

    // The output register only moves on an accepted fetch, so a held word stays
    // stable even if the load port rewrites its address.
    always_ff @(posedge clk) begin
        if (rst) begin
            inst_q <= '0;
            par_q  <= 1'b0;
        end else if (accept) begin
            inst_q <= rd_word;
            par_q  <= rd_par_err;
        end
    end

    // Storage has no reset so a program survives rst.
    always_ff @(posedge clk) begin
        if (ld_en && ld_ok) mem[ld_addr] <= ld_data;
    end

`ifdef INST_MEM_PARITY_EN
    logic par_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (ld_en && ld_ok) par_mem[ld_addr] <= ^ld_data;
    end

    assign rd_par_err = addr_ok && ((^mem[addr]) != par_mem[addr]);
`else
    assign rd_par_err = 1'b0;
`endif

endmodule

// File: tb/tb_inst_mem.sv
// Self-checking bench for inst_mem (DEPTH=21) with a scoreboard on the output handshake.
module tb_inst_mem;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int DEPTH = 21;
  localparam int W = DW + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req = 1'b0;
  logic [AW-1:0] addr = '0;
  logic          req_ready;
  logic          inst_valid;
  logic          inst_ready = 1'b0;
  logic [DW-1:0] inst;
  logic          ld_en = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [DW-1:0] ld_data = '0;
  logic          par_err;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  logic [DW-1:0] model_mem [32];
  logic corrupt3 = 1'b0;

  inst_mem #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .req(req), .addr(addr), .req_ready(req_ready),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .par_err(par_err)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard: consume presented word, then record an accepted fetch
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (inst_valid && inst_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got inst=%h par_err=%b, required no word", inst, par_err);
      end else begin
        e = exp_q.pop_front();
        if ({par_err, inst} !== e) begin
          errors++;
          $display("FAIL sb_word: got par_err=%b inst=%h, required par_err=%b inst=%h",
                   par_err, inst, e[DW], e[DW-1:0]);
        end
      end
    end
    if (rst) exp_q.delete();
    else if (req && req_ready) begin
      if (int'(addr) < DEPTH) e = {(addr == 3) && corrupt3, model_mem[addr]};
      else                    e = '0;
      exp_q.push_back(e);
    end
    if (ld_en && int'(ld_addr) < DEPTH) model_mem[ld_addr] = ld_data;
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    tick();
    ld_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    checks++;
    if (inst_valid !== 1'b0 || inst !== '0 || par_err !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: got valid=%b inst=%h par=%b rdy=%b, required 0 0 0 1",
               inst_valid, inst, par_err, req_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] prog [4];
    prog[0] = 32'h24010001; prog[1] = 32'h00011100;
    prog[2] = 32'h00411821; prog[3] = 32'h00022082;
    for (int i = 0; i < 4; i++) load(AW'(i), prog[i]);
    for (int i = 4; i < DEPTH; i++) load(AW'(i), $urandom());
    inst_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req = 1'b1; addr = AW'(i);
      tick();
      checks++;
      if (inst_valid !== 1'b1 || inst !== prog[i]) begin
        errors++;
        $display("FAIL b2b_cycle%0d: got valid=%b inst=%h, required 1 %h", i + 1, inst_valid, inst, prog[i]);
      end
    end
    req = 1'b0;
    tick();
    checks++;
    if (inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain: got valid=%b, required 0", inst_valid);
    end
  endtask

  task automatic test_hold_and_load();
    inst_ready = 1'b0;
    req = 1'b1; addr = 2;
    tick();
    req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (inst_valid !== 1'b1 || inst !== 32'h00411821 || par_err !== 1'b0) begin
        errors++;
        $display("FAIL hold_stable: got valid=%b inst=%h par=%b, required 1 00411821 0", inst_valid, inst, par_err);
      end
    end
    req = 1'b1; addr = 2;
    ld_en = 1'b1; ld_addr = 2; ld_data = 32'hDEADBEEF;
    #1;
    checks++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("FAIL hold_load_ready: got req_ready=%b, required 0", req_ready);
    end
    tick();
    ld_en = 1'b0; req = 1'b0;
    checks++;
    if (inst !== 32'h00411821) begin
      errors++;
      $display("FAIL hold_after_load: got inst=%h, required 00411821", inst);
    end
    inst_ready = 1'b1;
    tick();
    req = 1'b1; addr = 2;
    tick();
    req = 1'b0;
    checks++;
    if (inst_valid !== 1'b1 || inst !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL hold_refetch: got valid=%b inst=%h, required 1 deadbeef", inst_valid, inst);
    end
    tick();
  endtask

  task automatic test_load_priority();
    logic [DW-1:0] d;
    d = $urandom();
    inst_ready = 1'b1;
    ld_en = 1'b1; ld_addr = 5; ld_data = d;
    req = 1'b1; addr = 5;
    #1;
    checks++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("FAIL prio_ready: got req_ready=%b, required 0", req_ready);
    end
    tick();
    ld_en = 1'b0;
    tick();
    req = 1'b0;
    checks++;
    if (inst_valid !== 1'b1 || inst !== d) begin
      errors++;
      $display("FAIL prio_new_data: got valid=%b inst=%h, required 1 %h", inst_valid, inst, d);
    end
    tick();
  endtask

  task automatic test_out_of_range();
    logic [AW-1:0] oob [2];
    oob[0] = 21; oob[1] = 31;
    inst_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req = 1'b1; addr = oob[i];
      tick();
      checks++;
      if (inst_valid !== 1'b1 || inst !== '0 || par_err !== 1'b0) begin
        errors++;
        $display("FAIL oob_addr%0d: got valid=%b inst=%h par=%b, required 1 0 0", oob[i], inst_valid, inst, par_err);
      end
    end
    req = 1'b0;
    load(25, 32'h12345678);
    req = 1'b1; addr = 25;
    tick();
    req = 1'b0;
    checks++;
    if (inst_valid !== 1'b1 || inst !== '0) begin
      errors++;
      $display("FAIL oob_load_ignored: got valid=%b inst=%h, required 1 0", inst_valid, inst);
    end
    tick();
  endtask

  task automatic test_reset_flush();
    inst_ready = 1'b0;
    req = 1'b1; addr = 0;
    tick();
    req = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (inst_valid !== 1'b0 || inst !== '0) begin
      errors++;
      $display("FAIL rst_flush: got valid=%b inst=%h, required 0 0", inst_valid, inst);
    end
    tick();
    checks++;
    if (inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_no_word: got valid=%b, required 0", inst_valid);
    end
    inst_ready = 1'b1;
    req = 1'b1; addr = 1;
    tick();
    req = 1'b0;
    checks++;
    if (inst_valid !== 1'b1 || inst !== 32'h00011100) begin
      errors++;
      $display("FAIL rst_retained: got valid=%b inst=%h, required 1 00011100", inst_valid, inst);
    end
    tick();
  endtask

  task automatic test_parity();
    inst_ready = 1'b1;
`ifdef INST_MEM_PARITY_EN
    dut.par_mem[3] = ~dut.par_mem[3];
    corrupt3 = 1'b1;
`endif
    req = 1'b1; addr = 3;
    tick();
    req = 1'b0;
    checks++;
    if (inst !== 32'h00022082 || par_err !== corrupt3) begin
      errors++;
      $display("FAIL parity_addr3: got inst=%h par_err=%b, required 00022082 %b", inst, par_err, corrupt3);
    end
    tick();
`ifdef INST_MEM_PARITY_EN
    dut.par_mem[3] = ~dut.par_mem[3];
    corrupt3 = 1'b0;
`endif
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      req        = ($urandom_range(0, 3) != 0);
      addr       = AW'($urandom_range(0, 31));
      inst_ready = ($urandom_range(0, 3) != 0);
      ld_en      = ($urandom_range(0, 7) == 0);
      ld_addr    = AW'($urandom_range(0, 31));
      ld_data    = $urandom();
      tick();
    end
    req = 1'b0; ld_en = 1'b0; inst_ready = 1'b1;
    tick(); tick();
    checks++;
    if (exp_q.size() != 0 || inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL random_drain: got %0d pending valid=%b, required 0 pending valid=0", exp_q.size(), inst_valid);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_hold_and_load();
    test_load_priority();
    test_out_of_range();
    test_reset_flush();
    test_parity();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
